// File: rtl/mux_pipe_pkg.sv
// Shared state encoding, limits and select-width helper for the N:1 pipelined line mux.
package mux_pipe_pkg;

   localparam int MAX_NUM_INPUTS = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   // A single-line mux still needs a 1-bit select port.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mux_n_1_comb.sv
// Purpose: combinational N:1 selection of WIDTH-bit lines; out-of-range select gives zeros.
// Latency: none (purely combinational).
// Backpressure: none; the caller owns all flow control.
module mux_n_1_comb
   import mux_pipe_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int NUM_INPUTS = 4,
   parameter int SEL_WIDTH  = sel_width(NUM_INPUTS)
) (
   input  logic [NUM_INPUTS*WIDTH-1:0] lines_i,
   input  logic [SEL_WIDTH-1:0]        sel_i,
   output logic [WIDTH-1:0]            line_o
);

   always_comb begin
      line_o = '0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         if (int'(sel_i) == k) begin
            line_o = lines_i[k*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/mux_n_1_pipe.sv
// Purpose: N:1 line mux with registered output and a 2-entry skid (main + skid); MUX_N_1_PIPE_SEL_CHECK_EN adds a sticky select_error.
// Latency: 1 cycle from accept to output_line when empty; 1 result/cycle while out_ready is high.
// Backpressure: absorbs one extra entry; in_ready is registered (low only when both entries are full).
module mux_n_1_pipe
   import mux_pipe_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int NUM_INPUTS = 4,
   localparam int SEL_WIDTH = sel_width(NUM_INPUTS)
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [NUM_INPUTS*WIDTH-1:0] lines,
   input  logic [SEL_WIDTH-1:0]        select,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        flush,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            output_line,
   output logic                        select_error
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_dat_q, main_dat_d;
   logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
   logic             in_rdy_q;
   logic [WIDTH-1:0] mux_dat;
   logic             accept;
   logic             drain;

   mux_n_1_comb #(
      .WIDTH      (WIDTH),
      .NUM_INPUTS (NUM_INPUTS),
      .SEL_WIDTH  (SEL_WIDTH)
   ) u_mux (
      .lines_i (lines),
      .sel_i   (select),
      .line_o  (mux_dat)
   );

   assign accept      = in_valid & in_rdy_q;
   assign drain       = out_valid & out_ready;
   assign in_ready    = in_rdy_q;
   assign out_valid   = (state_q != EMPTY);
   assign output_line = main_dat_q;

   always_comb begin
      state_d    = state_q;
      main_dat_d = main_dat_q;
      skid_dat_d = skid_dat_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d    = ONE;
               main_dat_d = mux_dat;
            end
         end
         ONE: begin
            if (accept && drain) begin
               main_dat_d = mux_dat;
            end else if (accept) begin
               state_d    = TWO;
               skid_dat_d = mux_dat;
            end else if (drain) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            // in_ready is low here, so only a drain can move the state.
            if (drain) begin
               state_d    = ONE;
               main_dat_d = skid_dat_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush wins over everything, including a same-cycle accept.
      if (flush) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= EMPTY;
         main_dat_q <= '0;
         skid_dat_q <= '0;
         in_rdy_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_dat_q <= main_dat_d;
         skid_dat_q <= skid_dat_d;
         in_rdy_q   <= (state_d != TWO);
      end
   end

`ifdef MUX_N_1_PIPE_SEL_CHECK_EN
   logic sel_err_q;

   // Sticky until reset; flush deliberately leaves it alone.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sel_err_q <= 1'b0;
      end else if (accept && (int'(select) >= NUM_INPUTS)) begin
         sel_err_q <= 1'b1;
      end
   end

   assign select_error = sel_err_q;
`else
   assign select_error = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Scoreboard bench for mux_n_1_pipe: directed runs on 4-line and 3-line instances,
// then random valid/ready streams on 16x64 and 2x8 instances.
module tb_mux_n_1_pipe;

`ifdef MUX_N_1_PIPE_SEL_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic a_rst_n;

   always #5 clk = ~clk;

   // Instance A: 4 x 32
   logic [127:0] a_lines;
   logic [1:0]   a_sel;
   logic         a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_err;
   logic [31:0]  a_line;
   // Instance B: 3 x 32 (has out-of-range select codes)
   logic [95:0]  b_lines;
   logic [1:0]   b_sel;
   logic         b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_err;
   logic [31:0]  b_line;
   // Instance C: 16 x 64
   logic [1023:0] c_lines;
   logic [3:0]    c_sel;
   logic          c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready, c_err;
   logic [63:0]   c_line;
   logic [63:0]   c_words [16];
   // Instance D: 2 x 8
   logic [15:0]  d_lines;
   logic [0:0]   d_sel;
   logic         d_in_valid, d_in_ready, d_flush, d_out_valid, d_out_ready, d_err;
   logic [7:0]   d_line;
   logic [7:0]   d_words [2];

   logic [63:0] q_a [$];
   logic [63:0] q_b [$];
   logic [63:0] q_c [$];
   logic [63:0] q_d [$];

   int  n_checks = 0;
   int  n_errs   = 0;
   logic rnd_done;

   mux_n_1_pipe #(.WIDTH(32), .NUM_INPUTS(4)) u_a (
      .clock(clk), .reset_n(a_rst_n), .lines(a_lines), .select(a_sel),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .flush(a_flush),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .output_line(a_line), .select_error(a_err));

   mux_n_1_pipe #(.WIDTH(32), .NUM_INPUTS(3)) u_b (
      .clock(clk), .reset_n(rst_n), .lines(b_lines), .select(b_sel),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(b_flush),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .output_line(b_line), .select_error(b_err));

   mux_n_1_pipe #(.WIDTH(64), .NUM_INPUTS(16)) u_c (
      .clock(clk), .reset_n(rst_n), .lines(c_lines), .select(c_sel),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .flush(c_flush),
      .out_valid(c_out_valid), .out_ready(c_out_ready),
      .output_line(c_line), .select_error(c_err));

   mux_n_1_pipe #(.WIDTH(8), .NUM_INPUTS(2)) u_d (
      .clock(clk), .reset_n(rst_n), .lines(d_lines), .select(d_sel),
      .in_valid(d_in_valid), .in_ready(d_in_ready), .flush(d_flush),
      .out_valid(d_out_valid), .out_ready(d_out_ready),
      .output_line(d_line), .select_error(d_err));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_errs++;
      $display("FAIL %s", name);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offer one transfer on A; the expected line goes on the scoreboard when the handshake is seen.
   task automatic send_a(input logic [1:0] s, input logic [31:0] exp);
      logic got;
      got = 1'b0;
      a_sel      = s;
      a_in_valid = 1'b1;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         if (a_in_ready) begin
            q_a.push_back(64'(exp));
            got = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!got) fail("a_accept_timeout");
   endtask

   task automatic send_b(input logic [1:0] s, input logic [31:0] exp);
      logic got;
      got = 1'b0;
      b_sel      = s;
      b_in_valid = 1'b1;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         if (b_in_ready) begin
            q_b.push_back(64'(exp));
            got = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      b_in_valid = 1'b0;
      if (!got) fail("b_accept_timeout");
   endtask

   task automatic run_c(input int n);
      for (int i = 0; i < n; i++) begin
         int   s;
         logic got;
         s = $urandom_range(0, 15);
         for (int k = 0; k < 16; k++) begin
            c_words[k] = {$urandom, $urandom};
            c_lines[k*64 +: 64] = c_words[k];
         end
         c_sel      = 4'(s);
         c_in_valid = 1'b1;
         got        = 1'b0;
         for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (c_in_ready) begin
               q_c.push_back(c_words[s]);
               got = 1'b1;
            end
            @(posedge clk);
            #1;
         end
         c_in_valid = 1'b0;
         if (!got) fail("c_accept_timeout");
         if ($urandom_range(0, 3) == 0) cyc(1);
      end
   endtask

   task automatic run_d(input int n);
      for (int i = 0; i < n; i++) begin
         int   s;
         logic got;
         s = $urandom_range(0, 1);
         for (int k = 0; k < 2; k++) begin
            d_words[k] = 8'($urandom_range(0, 255));
            d_lines[k*8 +: 8] = d_words[k];
         end
         d_sel      = 1'(s);
         d_in_valid = 1'b1;
         got        = 1'b0;
         for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (d_in_ready) begin
               q_d.push_back(64'(d_words[s]));
               got = 1'b1;
            end
            @(posedge clk);
            #1;
         end
         d_in_valid = 1'b0;
         if (!got) fail("d_accept_timeout");
         if ($urandom_range(0, 3) == 0) cyc(1);
      end
   endtask

   // Monitors: pop and compare whenever an output handshake is about to complete.
   always @(negedge clk) begin
      if (a_rst_n && a_out_valid && a_out_ready) begin
         if (q_a.size() == 0) fail("a_unexpected_output");
         else check("a_data", 64'(a_line), q_a.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst_n && b_out_valid && b_out_ready) begin
         if (q_b.size() == 0) fail("b_unexpected_output");
         else check("b_data", 64'(b_line), q_b.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst_n && c_in_valid !== 1'bx) begin
         check("c_no_x", 64'($isunknown({c_out_valid, c_in_ready, c_line, c_err})), 64'd0);
         if (c_out_valid && c_out_ready) begin
            if (q_c.size() == 0) fail("c_unexpected_output");
            else check("c_data", c_line, q_c.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && d_in_valid !== 1'bx) begin
         check("d_no_x", 64'($isunknown({d_out_valid, d_in_ready, d_line, d_err})), 64'd0);
         if (d_out_valid && d_out_ready) begin
            if (q_d.size() == 0) fail("d_unexpected_output");
            else check("d_data", 64'(d_line), q_d.pop_front());
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;  a_rst_n = 1'b0;  rnd_done = 1'b0;
      a_lines = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
      b_lines = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
      c_lines = '0;  d_lines = '0;
      a_sel = '0;  b_sel = '0;  c_sel = '0;  d_sel = '0;
      a_in_valid = 1'b0;  b_in_valid = 1'b0;  c_in_valid = 1'b0;  d_in_valid = 1'b0;
      a_flush = 1'b0;  b_flush = 1'b0;  c_flush = 1'b0;  d_flush = 1'b0;
      a_out_ready = 1'b0;  b_out_ready = 1'b0;  c_out_ready = 1'b0;  d_out_ready = 1'b0;
      cyc(3);
      rst_n = 1'b1;  a_rst_n = 1'b1;

      check("a_rst_out_valid", 64'(a_out_valid), 64'd0);
      check("a_rst_line", 64'(a_line), 64'd0);
      check("a_rst_in_ready", 64'(a_in_ready), 64'd1);
      check("a_rst_select_error", 64'(a_err), 64'd0);

      // Basic path: 1-cycle latency, then back-to-back streaming
      a_out_ready = 1'b1;
      send_a(2'd2, 32'hCCCC0002);
      check("a_lat_valid", 64'(a_out_valid), 64'd1);
      check("a_lat_line", 64'(a_line), 64'hCCCC0002);
      send_a(2'd0, 32'hAAAA0000);
      check("a_stream0", 64'(a_line), 64'hAAAA0000);
      send_a(2'd1, 32'hBBBB0001);
      check("a_stream1", 64'(a_line), 64'hBBBB0001);
      send_a(2'd3, 32'hDDDD0003);
      check("a_stream3", 64'(a_line), 64'hDDDD0003);
      a_in_valid = 1'b0;
      cyc(2);
      check("a_drained_valid", 64'(a_out_valid), 64'd0);

      // Back-pressure: fill both entries, output holds, then drains in order
      a_out_ready = 1'b0;
      send_a(2'd1, 32'hBBBB0001);
      send_a(2'd3, 32'hDDDD0003);
      a_in_valid = 1'b0;
      check("a_bp_in_ready", 64'(a_in_ready), 64'd0);
      check("a_bp_line", 64'(a_line), 64'hBBBB0001);
      cyc(2);
      check("a_bp_hold_line", 64'(a_line), 64'hBBBB0001);
      check("a_bp_hold_ready", 64'(a_in_ready), 64'd0);
      a_out_ready = 1'b1;
      cyc(3);
      check("a_bp_ready_back", 64'(a_in_ready), 64'd1);
      check("a_bp_empty", 64'(a_out_valid), 64'd0);
      check("a_bp_queue_empty", 64'(q_a.size()), 64'd0);

      // Flush from TWO with in_valid high
      a_out_ready = 1'b0;
      send_a(2'd0, 32'hAAAA0000);
      send_a(2'd1, 32'hBBBB0001);
      a_flush = 1'b1;  a_sel = 2'd2;  a_in_valid = 1'b1;
      @(negedge clk);
      q_a.delete();
      @(posedge clk);
      #1;
      a_flush = 1'b0;  a_in_valid = 1'b0;
      check("a_flush2_valid", 64'(a_out_valid), 64'd0);
      check("a_flush2_in_ready", 64'(a_in_ready), 64'd1);
      // Flush from ONE with a same-cycle accept, which must be discarded
      send_a(2'd3, 32'hDDDD0003);
      a_flush = 1'b1;  a_sel = 2'd2;  a_in_valid = 1'b1;
      @(negedge clk);
      q_a.delete();
      @(posedge clk);
      #1;
      a_flush = 1'b0;  a_in_valid = 1'b0;
      check("a_flush1_valid", 64'(a_out_valid), 64'd0);
      a_out_ready = 1'b1;
      cyc(3);
      check("a_flush_nothing_out", 64'(a_out_valid), 64'd0);
      send_a(2'd2, 32'hCCCC0002);
      a_in_valid = 1'b0;
      check("a_post_flush_line", 64'(a_line), 64'hCCCC0002);
      cyc(2);

      // Asynchronous reset between clock edges while full
      a_out_ready = 1'b0;
      send_a(2'd0, 32'hAAAA0000);
      send_a(2'd1, 32'hBBBB0001);
      a_in_valid = 1'b0;
      #2;
      a_rst_n = 1'b0;
      #1;
      check("a_arst_valid", 64'(a_out_valid), 64'd0);
      check("a_arst_line", 64'(a_line), 64'd0);
      check("a_arst_in_ready", 64'(a_in_ready), 64'd1);
      q_a.delete();
      cyc(2);
      a_rst_n = 1'b1;
      a_out_ready = 1'b1;
      send_a(2'd2, 32'hCCCC0002);
      a_in_valid = 1'b0;
      check("a_after_rst_valid", 64'(a_out_valid), 64'd1);
      check("a_after_rst_line", 64'(a_line), 64'hCCCC0002);
      cyc(2);

      // Out-of-range select on the 3-line instance
      b_out_ready = 1'b1;
      check("b_rst_select_error", 64'(b_err), 64'd0);
      send_b(2'd0, 32'hAAAA0000);
      check("b_inrange_no_error", 64'(b_err), 64'd0);
      send_b(2'd3, 32'h00000000);
      check("b_oob_line_zero", 64'(b_line), 64'd0);
      check("b_oob_valid", 64'(b_out_valid), 64'd1);
      check("b_oob_select_error", 64'(b_err), 64'(EXP_ERR));
      send_b(2'd1, 32'hBBBB0001);
      check("b_after_oob_line", 64'(b_line), 64'hBBBB0001);
      cyc(2);
      b_flush = 1'b1;
      cyc(1);
      b_flush = 1'b0;
      check("b_err_after_flush", 64'(b_err), 64'(EXP_ERR));
      check("b_flush_valid", 64'(b_out_valid), 64'd0);
      check("b_queue_empty", 64'(q_b.size()), 64'd0);

      // Random valid/ready streams on the 16x64 and 2x8 instances
      fork
         begin
            fork
               run_c(2500);
               run_d(2500);
            join
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               c_out_ready = 1'($urandom_range(0, 1));
               d_out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      c_out_ready = 1'b1;
      d_out_ready = 1'b1;
      cyc(5);
      check("c_queue_drained", 64'(q_c.size()), 64'd0);
      check("d_queue_drained", 64'(q_d.size()), 64'd0);
      check("c_select_error", 64'(c_err), 64'd0);
      check("d_select_error", 64'(d_err), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
